// File: rtl/imem_loader.sv
// imem_loader: receives a byte stream, packs little-endian byte pairs into
// 16-bit words and writes them to consecutive instruction memory addresses
// while the CPU is held off through busy.
module imem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LO    = 2'd1,
    S_HI    = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] L_ONE   = (ADDR_W + 1)'(1);

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_count;
  logic [7:0]          r_lo;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [15:0]         r_wr_data;
  logic                r_done;
  logic                r_err;

  logic                w_start_legal;
  logic                w_start_ok;
  logic                w_start_bad;
  logic                w_last;
  logic                w_xfer;

  // abort has priority over start in IDLE, so both qualified starts exclude it
  assign w_start_legal = (word_count != '0) && (word_count <= L_DEPTH);
  assign w_start_ok    = start && !abort && w_start_legal;
  assign w_start_bad   = start && !abort && !w_start_legal;
  // Counter is compared one bit wider so a count of DEPTH ends at DEPTH-1
  // instead of wrapping.
  assign w_last        = ({1'b0, r_addr} == (r_count - L_ONE));
  assign w_xfer        = byte_ready && byte_valid;

  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign err     = r_err;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state decode plus byte_ready / wr_en, which depend only on state and abort
  // NOTE: every output of this block gets a default first so no path leaves
  // a value unassigned and infers a latch.
  always_comb begin
    w_next_state = r_state;
    byte_ready   = 1'b0;
    wr_en        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_next_state = S_LO;
      end
      S_LO: begin
        byte_ready = !abort;
        if (abort)           w_next_state = S_IDLE;
        else if (byte_valid) w_next_state = S_HI;
      end
      S_HI: begin
        byte_ready = !abort;
        if (abort)           w_next_state = S_IDLE;
        else if (byte_valid) w_next_state = S_WRITE;
      end
      S_WRITE: begin
        wr_en = 1'b1;
        if (abort || w_last) w_next_state = S_IDLE;
        else                 w_next_state = S_LO;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Session datapath: count/address, byte packing, write port and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_count   <= '0;
      r_lo      <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_count <= word_count;
            r_addr  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
          end else if (w_start_bad) begin
            r_err  <= 1'b1;
            r_done <= 1'b0;
          end
        end
        S_LO: begin
          if (w_xfer) r_lo <= byte_data;
        end
        S_HI: begin
          // Write port is loaded here so it is valid during WRITE and holds after
          if (w_xfer) begin
            r_wr_data <= {byte_data, r_lo};
            r_wr_addr <= r_addr;
          end
        end
        S_WRITE: begin
          if (!abort) begin
            if (w_last) r_done <= 1'b1;
            else        r_addr <= r_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: DEPTH, 64, number of 16-bit instruction words in the target instruction memory.
REQ-002 Parameter: ADDR_W, 6, write address width; SHALL satisfy 2**ADDR_W == DEPTH.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to begin a load session.
REQ-006 word_count  in  ADDR_W+1  number of words to load, sampled only when start is accepted.
REQ-007 abort  in  1  terminate the current session immediately.
REQ-008 byte_valid  in  1  upstream byte available.
REQ-009 byte_data  in  8  upstream byte.
REQ-010 byte_ready  out  1  loader accepts byte_data this cycle.
REQ-011 wr_en  out  1  one-cycle write strobe to the instruction memory.
REQ-012 wr_addr  out  ADDR_W  write word address.
REQ-013 wr_data  out  16  write word.
REQ-014 busy  out  1  session in progress; the CPU is held while it is high.
REQ-015 done  out  1  sticky flag: last session completed all words.
REQ-016 err  out  1  sticky flag: last start request had an illegal word_count.

Function
REQ-017 FSM states: IDLE, LO, HI, WRITE.
REQ-018 A byte transfer SHALL occur only on a cycle where byte_valid and byte_ready are both high.
REQ-019 byte_ready SHALL be high only in LO or HI while abort is low; it is combinational from state and abort only, never from byte_valid.
REQ-020 In IDLE, start with 1 <= word_count <= DEPTH: latch word_count, clear the address counter to 0, clear done and err, set busy, go to LO.
REQ-021 In IDLE, start with word_count == 0 or > DEPTH: set err, clear done, stay in IDLE, no write.
REQ-022 start in LO, HI or WRITE SHALL be ignored.
REQ-023 LO: a transfer latches byte_data as the low byte and goes to HI; with no transfer, stay in LO.
REQ-024 HI: a transfer latches byte_data as the high byte and goes to WRITE.
REQ-025 Byte order is little-endian: the first byte is wr_data[7:0] and the second is wr_data[15:8].
REQ-026 WRITE lasts exactly one cycle: wr_en=1, wr_addr=address counter, wr_data={high,low}, byte_ready=0.
REQ-027 Latency: wr_en SHALL assert on the cycle after the high-byte transfer.
REQ-028 Leaving WRITE when address counter == latched count-1: go to IDLE, clear busy, set done.
REQ-029 Leaving WRITE otherwise: increment the address counter by 1 and go to LO.
REQ-030 The address counter SHALL never wrap: count == DEPTH ends the session at address DEPTH-1.
REQ-031 wr_en SHALL be 0 in every state other than WRITE; wr_addr and wr_data SHALL hold their last values when wr_en=0.
REQ-032 abort high in LO or HI: go to IDLE next cycle, clear busy, leave done=0, discard any partial byte, write nothing further.
REQ-033 abort during WRITE: the write in that cycle SHALL complete, then go to IDLE with done=0.
REQ-034 Words already written before an abort SHALL NOT be rolled back.
REQ-035 abort and start in the same IDLE cycle: abort wins and start is ignored.
REQ-036 done and err SHALL be mutually exclusive and SHALL hold until the next accepted or rejected start.

Reset
REQ-037 rst_n low SHALL immediately force state=IDLE, address counter=0, data latches=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, byte_ready=0.
REQ-038 Reset asserted mid-session SHALL abandon the session with no further writes; recovery requires a new start.

Verification
REQ-039 start with word_count=2, bytes 34,12,CD,AB streamed back-to-back -> wr_en at addr0 with data 1234, then at addr1 with data ABCD; busy falls and done=1 after the second write.
REQ-040 start with word_count=0, then with word_count=65 -> err=1 each time, busy stays 0, no wr_en.
REQ-041 start with word_count=64, 128 bytes with random byte_valid gaps -> 64 writes to addresses 0..63 in order, no wrap, done=1.
REQ-042 abort asserted after 1.5 words (count=4) -> one write at addr0, then IDLE, done=0, byte_ready=0; a new start with count=1 writes at addr0.
REQ-043 rst_n pulsed low while in HI -> all outputs 0 immediately, no wr_en after reset release until a new start.
REQ-044 start held high during a session, and start+abort together in IDLE -> no restart and no session begins.
